scr1_avl_port_arbiter: RTL and testbench
========================================

// Module: scr1_avl_port_arbiter
// PURPOSE
// - Two-master, one-slave Avalon-MM arbiter: the imem and dmem AHB-to-Avalon bridges share one fabric port.
// - Sits between the two bridges' Avalon master sides and a single Avalon slave port into the system interconnect.
// - Serialises commands, tracks outstanding reads and routes pipelined read responses back to the issuing master.
// PARAMETERS
// - ADDR_W      32  Avalon address width
// - DATA_W      32  Avalon data width; byteenable width is DATA_W/8
// - MAX_OUTST   4   max outstanding reads (power of 2, >=2)
// - FIXED_PRIO  0   0 = round-robin; 1 = dmem (m1) always wins
// PORTS
// - clk_riscv           in   1         core clock
// - rst_in              in   1         reset, asynchronous, active-low
// - m{0,1}_read         in   1         read request (m0 = imem, m1 = dmem)
// - m{0,1}_write        in   1         write request
// - m{0,1}_address      in   ADDR_W    byte address
// - m{0,1}_byteenable   in   DATA_W/8  byte lanes
// - m{0,1}_writedata    in   DATA_W    write data
// - m{0,1}_waitrequest  out  1         command stall to master
// - m{0,1}_readdatavalid out 1         read response strobe
// - m{0,1}_readdata     out  DATA_W    read data (broadcast to both masters)
// - m{0,1}_response     out  2         response code (broadcast to both masters)
// - s_read/s_write      out  1         command to slave
// - s_address/s_byteenable/s_writedata  out  —  muxed from the granted master
// - s_waitrequest       in   1         slave stall
// - s_readdatavalid     in   1         slave read response
// - s_readdata          in   DATA_W    slave read data
// - s_response          in   2         slave response code
// - err_orphan          out  1         sticky: read response arrived with no outstanding read
// BEHAVIOUR
// - Reset values: s_read=0, s_write=0, m*_waitrequest=1, m*_readdatavalid=0, err_orphan=0.
// - Reset also sets: FIFO empty, last-grant = m1 (so m0 wins the first tie), state = IDLE.
// - FSM IDLE
//   - Arbitrate combinationally among eligible requesters; drive the winner's command onto s_* in the same cycle.
//   - Eligible: write requests always; read requests only when rd_cnt < MAX_OUTST.
//   - Accept: s_waitrequest=0 -> winner's waitrequest=0 for that cycle, command is done, stay in IDLE.
//   - Stall: s_waitrequest=1 -> go to HOLD with grant latched.
// - FSM HOLD
//   - Present the latched master's command unchanged (Avalon stability rule); the grant cannot be preempted.
//   - Return to IDLE on the cycle s_waitrequest=0.
// - The loser's and any ineligible master's waitrequest is held at 1.
// - Round-robin: on every accepted command last-grant is updated; a tie goes to the master not granted last.
// - FIXED_PRIO=1: m1 wins every tie; m0 can starve, and that is intended.
// - A master asserting read and write together is a protocol violation: write is taken, read is ignored.
// - Response-ID FIFO
//   - Depth MAX_OUTST, 1-bit entries (master ID).
//   - Push on each accepted read; pop on each s_readdatavalid.
//   - rd_cnt = FIFO occupancy.
//   - Push and pop in the same cycle: both take effect, count unchanged.
//   - Full: reads are blocked and writes still proceed. No full bypass, even if a pop occurs in the same cycle.
//   - Empty + s_readdatavalid: response is dropped, err_orphan sets and stays set until reset.
// - Response routing
//   - m{id}_readdatavalid = s_readdatavalid & (FIFO head == id), combinational with zero latency.
//   - readdata and response are wired through unregistered to both masters.
// - Latency: zero added cycles on commands and responses; the only combinational paths are s_waitrequest -> m*_waitrequest and the muxes.
// - Writes carry no response and never touch the FIFO.
// - Pointer wrap: log2(MAX_OUTST)-bit read and write pointers wrap naturally; a separate count is (log2+1) bits.
// - Reset mid-operation
//   - Everything returns to reset values immediately (asynchronous).
//   - Responses for reads issued before reset are orphans after reset and set err_orphan.
//   - The integrating design must quiesce the slave before release; err_orphan makes a violation observable.
// STRUCTURE
// - Package scr1_avl_arb_pkg: typedef enum {ARB_IDLE, ARB_HOLD} arb_state_e; typedef logic arb_id_t.
// - Package constants: ARB_ID_IMEM=0, ARB_ID_DMEM=1.
// - One sub-module: scr1_avl_rsp_id_fifo (sync FIFO; push/pop/full/empty/head/count; parameters DEPTH, W=1).
// - Top level: FSM, arbiter, command muxes, response demux.
// TESTING
// - m0 read 0x100 and m1 read 0x200 in the same cycle, RR, s_waitrequest=0 -> m0 issues first, then m1.
//   - Responses D0, D1 arrive 3 cycles later -> m0_readdatavalid with D0, then m1_readdatavalid with D1.
// - m1 write 0x40 with s_waitrequest=1 for 4 cycles while m0 requests -> s_* stable 5 cycles, m0 waitrequest=1.
//   - Grant passes to m0 in the cycle after the m1 write is accepted.
// - MAX_OUTST=4, 4 m0 reads with no responses -> 5th read stalls while an m1 write is still accepted.
//   - One s_readdatavalid -> 5th read is issued the next cycle.
// - FIXED_PRIO=1, m0 and m1 both read continuously for 10 cycles -> all 10 grants go to m1, m0_waitrequest held at 1.
// - s_readdatavalid with FIFO empty -> no m*_readdatavalid, err_orphan=1 and held.
//   - rst_in low -> err_orphan=0.
// - rst_in asserted with 2 reads outstanding -> s_read=0 and waitrequests=1 immediately.
//   - After release, m0 read issues normally; a late old response sets err_orphan.

Source files
------------

// File: rtl/scr1_avl_arb_pkg.sv
// Shared types and constants for the imem/dmem Avalon port arbiter.
// Master IDs double as the response-ID FIFO payload.
package scr1_avl_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_ID_IMEM = 1'b0;
  localparam arb_id_t ARB_ID_DMEM = 1'b1;

endpackage

// File: rtl/scr1_avl_rsp_id_fifo.sv
// Synchronous FIFO of master IDs, one entry per outstanding read.
// DEPTH must be a power of two so the pointers wrap on their own.
module scr1_avl_rsp_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                       clk_riscv,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: the storage array has no reset; only pointers and count define
  // validity, so clearing the entries would cost reset fan-out for nothing.
  always_ff @(posedge clk_riscv) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scr1_avl_port_arbiter.sv
// Two-master (imem=m0, dmem=m1) to one-slave Avalon-MM arbiter with
// zero-latency command muxing and ID-tagged pipelined read response routing.
module scr1_avl_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTST  = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk_riscv,
  input  logic                rst_in,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic                m0_readdatavalid,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic [1:0]          m0_response,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic                m1_readdatavalid,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [1:0]          m1_response,
  output logic                s_read,
  output logic                s_write,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic                s_readdatavalid,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic [1:0]          s_response,
  output logic                err_orphan
);

  import scr1_avl_arb_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  arb_state_e       state;
  arb_id_t          hold_id;
  arb_id_t          last_id;
  arb_id_t          win_id;
  arb_id_t          sel_id;
  arb_id_t          fifo_head;
  logic             arb_en;
  logic             cmd_vld;
  logic             accept;
  logic             rd_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       req_wr;
  logic [1:0]       req_rd;
  logic [1:0]       elig;

  // A simultaneous read+write is resolved as a write; the read is dropped.
  assign req_wr = {m1_write, m0_write};
  assign req_rd = {m1_read & ~m1_write, m0_read & ~m0_write};
  assign rd_ok  = (rd_cnt < MAX_CNT);
  assign elig   = req_wr | (req_rd & {2{rd_ok}});

  // NOTE: always_comb assigns a default first, so no path can infer a latch.
  always_comb begin
    win_id = elig[1] ? ARB_ID_DMEM : ARB_ID_IMEM;
    if (elig == 2'b11) win_id = (FIXED_PRIO != 0) ? ARB_ID_DMEM : ~last_id;
  end

  // arb_en is cleared asynchronously by reset, so the combinational command
  // path is silenced the instant rst_in falls, not at the next clock edge.
  assign sel_id  = (state == ARB_HOLD) ? hold_id : win_id;
  assign cmd_vld = arb_en & ((state == ARB_HOLD) | (|elig));
  assign accept  = cmd_vld & ~s_waitrequest;

  assign s_read       = cmd_vld & req_rd[sel_id];
  assign s_write      = cmd_vld & req_wr[sel_id];
  assign s_address    = sel_id ? m1_address    : m0_address;
  assign s_byteenable = sel_id ? m1_byteenable : m0_byteenable;
  assign s_writedata  = sel_id ? m1_writedata  : m0_writedata;

  assign m0_waitrequest = ~(accept & (sel_id == ARB_ID_IMEM));
  assign m1_waitrequest = ~(accept & (sel_id == ARB_ID_DMEM));

  assign fifo_push = accept & s_read & ~fifo_full;

  scr1_avl_rsp_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (1)
  ) u_rsp_id_fifo (
    .clk_riscv (clk_riscv),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (sel_id),
    .pop       (s_readdatavalid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (rd_cnt)
  );

  assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == ARB_ID_IMEM);
  assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == ARB_ID_DMEM);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_response      = s_response;
  assign m1_response      = s_response;

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ARB_IDLE;
      hold_id    <= ARB_ID_IMEM;
      last_id    <= ARB_ID_DMEM;
      arb_en     <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      arb_en <= 1'b1;
      if (accept) last_id <= sel_id;
      if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (cmd_vld && s_waitrequest) begin
            state   <= ARB_HOLD;
            hold_id <= win_id;
          end
        end
        ARB_HOLD: begin
          if (!s_waitrequest) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_avl_port_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// the same master/slave stimulus; each scenario checks hand-computed values.
module tb_scr1_avl_port_arbiter;

  logic        clk_riscv;
  logic        rst_in;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [1:0]  m0_response, m1_response;
  logic        s_read, s_write, err_orphan;
  logic [31:0] s_address, s_writedata;
  logic [3:0]  s_byteenable;

  logic        f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
  logic [31:0] f_m0_readdata, f_m1_readdata;
  logic [1:0]  f_m0_response, f_m1_response;
  logic        f_s_read, f_s_write, f_err_orphan;
  logic [31:0] f_s_address, f_s_writedata;
  logic [3:0]  f_s_byteenable;

  int n_pass  = 0;
  int n_total = 0;

  scr1_avl_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .FIXED_PRIO(0)) u_rr (
    .clk_riscv(clk_riscv), .rst_in(rst_in),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_readdata(m0_readdata), .m0_response(m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata), .m1_response(m1_response),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata), .s_response(s_response), .err_orphan(err_orphan)
  );

  scr1_avl_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .FIXED_PRIO(1)) u_fix (
    .clk_riscv(clk_riscv), .rst_in(rst_in),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(f_m0_waitrequest), .m0_readdatavalid(f_m0_readdatavalid),
    .m0_readdata(f_m0_readdata), .m0_response(f_m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(f_m1_waitrequest), .m1_readdatavalid(f_m1_readdatavalid),
    .m1_readdata(f_m1_readdata), .m1_response(f_m1_response),
    .s_read(f_s_read), .s_write(f_s_write), .s_address(f_s_address),
    .s_byteenable(f_s_byteenable), .s_writedata(f_s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_readdata(s_readdata), .s_response(s_response), .err_orphan(f_err_orphan)
  );

  initial begin
    clk_riscv = 1'b0;
    forever #5 clk_riscv = ~clk_riscv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Returns 1 time unit after the rising edge; inputs are driven there and
  // outputs sampled one more unit later, well clear of either clock edge.
  task automatic tick();
    @(posedge clk_riscv);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0; s_response = 2'b00;

    // Reset state, with a request present that must not leak through.
    #1 rst_in = 1'b0;
    m0_read = 1; m0_address = 32'h100;
    tick(); #1;
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_m0_rdv", m0_readdatavalid, 0);
    check("rst_err_orphan", err_orphan, 0);
    m0_read = 0; rst_in = 1'b1;
    tick();

    // Simultaneous reads: m0 wins the first tie after reset, then m1.
    m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200; #1;
    check("tie_addr_m0", s_address, 32'h100);
    check("tie_s_read", s_read, 1);
    check("tie_m0_wait", m0_waitrequest, 0);
    check("tie_m1_wait", m1_waitrequest, 1);
    tick(); m0_read = 0; #1;
    check("second_addr_m1", s_address, 32'h200);
    check("second_m1_wait", m1_waitrequest, 0);
    check("second_m0_wait", m0_waitrequest, 1);
    tick(); m1_read = 0;
    tick(); tick();
    s_readdatavalid = 1; s_readdata = 32'hD0D0_0000; s_response = 2'b10; #1;
    check("rsp0_m0_rdv", m0_readdatavalid, 1);
    check("rsp0_m1_rdv", m1_readdatavalid, 0);
    check("rsp0_data", m0_readdata, 32'hD0D0_0000);
    check("rsp0_resp_bcast", m1_response, 2'b10);
    tick(); s_readdata = 32'hD1D1_1111; s_response = 2'b00; #1;
    check("rsp1_m1_rdv", m1_readdatavalid, 1);
    check("rsp1_m0_rdv", m0_readdatavalid, 0);
    check("rsp1_data", m1_readdata, 32'hD1D1_1111);
    tick(); s_readdatavalid = 0;

    // Continuous tie on writes alternates the grant.
    m0_write = 1; m0_address = 32'h10; m0_writedata = 32'h1111_1111;
    m1_write = 1; m1_address = 32'h20; m1_writedata = 32'h2222_2222; m1_byteenable = 4'h3; #1;
    check("rr_w1_addr", s_address, 32'h10);
    check("rr_w1_m0_wait", m0_waitrequest, 0);
    check("rr_w1_m1_wait", m1_waitrequest, 1);
    check("rr_w1_s_write", s_write, 1);
    tick(); #1;
    check("rr_w2_addr", s_address, 32'h20);
    check("rr_w2_wdata", s_writedata, 32'h2222_2222);
    check("rr_w2_be", s_byteenable, 4'h3);
    tick(); #1;
    check("rr_w3_addr", s_address, 32'h10);
    tick(); m0_write = 0; m1_write = 0; m1_byteenable = 4'hF;

    // m1 write stalled 4 cycles while m0 waits; command stays stable.
    m1_write = 1; m1_address = 32'h40; m1_writedata = 32'hCAFE_F00D;
    m0_read = 1; m0_address = 32'h80; s_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) s_waitrequest = 0;
      #1;
      check("hold_addr", s_address, 32'h40);
      check("hold_wdata", s_writedata, 32'hCAFE_F00D);
      check("hold_s_write", s_write, 1);
      check("hold_m0_wait", m0_waitrequest, 1);
      check("hold_m1_wait", m1_waitrequest, (i < 4) ? 1 : 0);
      tick();
    end
    m1_write = 0; #1;
    check("after_hold_s_read", s_read, 1);
    check("after_hold_addr", s_address, 32'h80);
    check("after_hold_m0_wait", m0_waitrequest, 0);
    tick(); m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h0000_00D2; #1;
    check("after_hold_rsp", m0_readdatavalid, 1);
    tick(); s_readdatavalid = 0;

    // Fill the FIFO with four m0 reads; fifth blocks, writes still pass.
    m0_read = 1;
    for (int i = 0; i < 4; i++) begin
      m0_address = 32'h1000 + 32'(i * 4); #1;
      check("fill_m0_wait", m0_waitrequest, 0);
      check("fill_addr", s_address, 32'h1000 + 32'(i * 4));
      tick();
    end
    m0_address = 32'h1010; m1_write = 1; m1_address = 32'h44; #1;
    check("full_s_write", s_write, 1);
    check("full_s_read", s_read, 0);
    check("full_addr", s_address, 32'h44);
    check("full_m1_wait", m1_waitrequest, 0);
    check("full_m0_wait", m0_waitrequest, 1);
    tick(); m1_write = 0; #1;
    check("full_alone_s_read", s_read, 0);
    check("full_alone_m0_wait", m0_waitrequest, 1);
    tick(); s_readdatavalid = 1; #1;
    check("full_pop_rdv", m0_readdatavalid, 1);
    check("full_no_bypass", m0_waitrequest, 1);
    tick(); s_readdatavalid = 0; #1;
    check("after_pop_s_read", s_read, 1);
    check("after_pop_addr", s_address, 32'h1010);
    check("after_pop_m0_wait", m0_waitrequest, 0);
    tick(); m0_read = 0; s_readdatavalid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_m0_rdv", m0_readdatavalid, 1);
      tick();
    end
    s_readdatavalid = 0;

    // Read+write together: write taken, nothing pushed.
    m0_read = 1; m0_write = 1; m0_address = 32'h300; #1;
    check("rdwr_s_write", s_write, 1);
    check("rdwr_s_read", s_read, 0);
    check("rdwr_m0_wait", m0_waitrequest, 0);
    tick(); m0_read = 0; m0_write = 0;

    // Response with an empty FIFO is an orphan; flag is sticky until reset.
    s_readdatavalid = 1; #1;
    check("orphan_m0_rdv", m0_readdatavalid, 0);
    check("orphan_m1_rdv", m1_readdatavalid, 0);
    tick(); s_readdatavalid = 0; #1;
    check("orphan_set", err_orphan, 1);
    tick(); #1;
    check("orphan_sticky", err_orphan, 1);
    rst_in = 1'b0; #1;
    check("orphan_cleared", err_orphan, 0);
    tick(); rst_in = 1'b1;
    tick();

    // Reset with two reads outstanding.
    m0_read = 1; m0_address = 32'h500; #1;
    check("pre_rst_m0_wait", m0_waitrequest, 0);
    tick(); tick();
    m1_read = 1; m1_address = 32'h504; rst_in = 1'b0; #1;
    check("mid_rst_s_read", s_read, 0);
    check("mid_rst_m0_wait", m0_waitrequest, 1);
    check("mid_rst_m1_wait", m1_waitrequest, 1);
    tick(); m0_read = 0; m1_read = 0; rst_in = 1'b1;
    tick();
    s_readdatavalid = 1; #1;
    check("late_rsp_m0_rdv", m0_readdatavalid, 0);
    check("late_rsp_m1_rdv", m1_readdatavalid, 0);
    tick(); s_readdatavalid = 0; #1;
    check("late_rsp_orphan", err_orphan, 1);
    m0_read = 1; m0_address = 32'h600; #1;
    check("post_rst_s_read", s_read, 1);
    check("post_rst_addr", s_address, 32'h600);
    check("post_rst_m0_wait", m0_waitrequest, 0);
    tick(); m0_read = 0; s_readdatavalid = 1; #1;
    check("post_rst_rsp", m0_readdatavalid, 1);
    tick(); s_readdatavalid = 0;

    // Fixed priority: m1 wins every cycle; round-robin instance alternates.
    rst_in = 1'b0; tick(); rst_in = 1'b1; tick();
    m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200;
    for (int k = 0; k < 10; k++) begin
      s_readdatavalid = (k >= 1); #1;
      check("fix_m1_wait", f_m1_waitrequest, 0);
      check("fix_m0_wait", f_m0_waitrequest, 1);
      check("fix_addr", f_s_address, 32'h200);
      if (k >= 1) check("fix_m1_rdv", f_m1_readdatavalid, 1);
      if (k == 0) check("rr_cmp_k0_m0_wait", m0_waitrequest, 0);
      if (k == 1) check("rr_cmp_k1_m1_wait", m1_waitrequest, 0);
      tick();
    end
    m0_read = 0; m1_read = 0; s_readdatavalid = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
